mem_arbiter: RTL and testbench

- Shares the single synchronous unified memory between two requesters: the multicycle core (port 0) and the program loader/debug port (port 1).
- Grants one requester at a time using round-robin arbitration.
- Holds the address, write data and strobes stable for a fixed number of wait-state cycles.
- Returns read data with a one-cycle ready pulse.
- Sits between the core/loader and the memory macro.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between the core (port 0)
// and the loader/debug port (port 1), with fixed wait states and a ready pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ready0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ready1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                state;
    logic [3:0]            count;
    logic                  last_grant;
    logic                  owner;
    logic                  lat_we;

    logic                  pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // On a tie the port that did not own the memory last time wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1)
            pick = ~last_grant;
        else if (req1)
            pick = 1'b1;
        sel_we    = pick ? we1    : we0;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
    end

    // mem_addr/mem_wdata double as the latched request, so they stay stable
    // for the whole access regardless of what the requester does afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 4'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            ready0     <= 1'b0;
            ready1     <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        lat_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_read  <= ~sel_we;
                        mem_write <= sel_we;
                        count     <= 4'(WAIT_STATES);
                        grant     <= pick ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!lat_we) begin
                            if (owner)
                                rdata1 <= mem_rdata;
                            else
                                rdata0 <= mem_rdata;
                        end
                        ready0 <= ~owner;
                        ready1 <= owner;
                        state  <= RESPOND;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESPOND: begin
                    last_grant <= owner;
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_STATES = 1) with a small synchronous
// memory model; all checks happen on the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ready0, ready1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [256];

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ready0(ready0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ready1(ready1), .rdata1(rdata1),
        .grant(grant), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after mem_read.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h40] <= 32'hDEADBEEF;
            mem[8'h80] <= 32'h0BADF00D;
        end
        if (mem_write)
            mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read)
            mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // {grant, busy, ready0, ready1, mem_read, mem_write}
    function automatic logic [6:0] ctl();
        return {grant, busy, ready0, ready1, mem_read, mem_write};
    endfunction

    initial begin
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        // Reset then idle
        repeat (2) @(negedge clk);
        check("reset_ctl", 64'(ctl()), 64'd0);
        check("reset_rdata", {rdata0, rdata1}, 64'd0);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctl", 64'(ctl()), 64'd0);
        end

        // Single read, port 0
        req0 = 1; we0 = 0; addr0 = 32'h40;
        @(negedge clk);
        check("rd0_c1_ctl", 64'(ctl()), 64'b01_1_00_10);
        check("rd0_c1_addr", 64'(mem_addr), 64'h40);
        @(negedge clk);
        check("rd0_c2_ctl", 64'(ctl()), 64'b01_1_00_10);
        @(negedge clk);
        check("rd0_c3_ctl", 64'(ctl()), 64'b01_1_10_00);
        check("rd0_rdata", {rdata0, rdata1}, {32'hDEADBEEF, 32'h0});
        req0 = 0;
        @(negedge clk);
        check("rd0_done_ctl", 64'(ctl()), 64'd0);

        // Single write, port 1
        req1 = 1; we1 = 1; addr1 = 32'h8; wdata1 = 32'h12345678;
        @(negedge clk);
        check("wr1_c1_ctl", 64'(ctl()), 64'b10_1_00_01);
        check("wr1_c1_bus", {mem_addr, mem_wdata}, {32'h8, 32'h12345678});
        @(negedge clk);
        check("wr1_c2_ctl", 64'(ctl()), 64'b10_1_00_01);
        @(negedge clk);
        check("wr1_c3_ctl", 64'(ctl()), 64'b10_1_01_00);
        check("wr1_rdata", {rdata0, rdata1}, {32'hDEADBEEF, 32'h0});
        req1 = 0;
        @(negedge clk);

        // Readback of the write through port 0
        req0 = 1; we0 = 0; addr0 = 32'h8;
        repeat (3) @(negedge clk);
        check("rb0_ctl", 64'(ctl()), 64'b01_1_10_00);
        check("rb0_rdata", {rdata0, rdata1}, {32'h12345678, 32'h0});
        req0 = 0;
        @(negedge clk);

        // Contention after reset: 0,1,0,1 with one IDLE cycle between
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 32'h40;
        req1 = 1; we1 = 0; addr1 = 32'h8;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("rr_grant", 64'(grant), (t % 2 == 0) ? 64'b01 : 64'b10);
            @(negedge clk);
            @(negedge clk);
            check("rr_ready", 64'({ready0, ready1}), (t % 2 == 0) ? 64'b10 : 64'b01);
            check("rr_rdata", (t % 2 == 0) ? 64'(rdata0) : 64'(rdata1),
                  (t % 2 == 0) ? 64'hDEADBEEF : 64'h12345678);
            if (t == 3) begin
                req0 = 0;
                req1 = 0;
            end
            @(negedge clk);
            check("rr_gap", 64'(ctl()), 64'd0);
        end

        // Input stability: address changes after grant are ignored
        req0 = 1; we0 = 0; addr0 = 32'h40;
        @(negedge clk);
        addr0 = 32'h80;
        @(negedge clk);
        check("stab_addr", 64'(mem_addr), 64'h40);
        @(negedge clk);
        check("stab_ready", 64'({ready0, ready1}), 64'b10);
        check("stab_rdata", 64'(rdata0), 64'hDEADBEEF);
        req0 = 0;
        @(negedge clk);

        // Reset mid-access aborts; port 0 wins the tie afterwards
        req0 = 1; we0 = 0; addr0 = 32'h40;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ctl", 64'(ctl()), 64'd0);
        check("abort_rdata", {rdata0, rdata1}, 64'd0);
        @(negedge clk);
        check("abort_noready", 64'({ready0, ready1}), 64'd0);
        rst_n = 1'b1;
        req1 = 1; we1 = 0; addr1 = 32'h8;
        @(negedge clk);
        check("post_rst_grant", 64'(grant), 64'b01);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", 64'({ready0, ready1}), 64'b10);
        check("post_rst_rdata", 64'(rdata0), 64'hDEADBEEF);
        req0 = 0;
        req1 = 0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
